// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises DATA_W+2 bit command frames, serialises
// DATA_W bit read responses, and flags malformed or truncated frames.
module spi_slave_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err
);

   localparam int FW = DATA_W + 2;
   localparam int CW = $clog2(FW);

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      RECV,
      WAIT_TX,
      SEND,
      DONE
   } state_t;

   state_t            r_state,     w_state;
   logic [CW-1:0]     r_cnt,       w_cnt;
   logic [FW-1:0]     r_rx_sh,     w_rx_sh;
   logic [DATA_W-1:0] r_tx_sh,     w_tx_sh;
   logic              r_mode,      w_mode;
   logic              r_addr_done, w_addr_done;
   logic              r_miso,      w_miso;
   logic [FW-1:0]     r_rx_data,   w_rx_data;
   logic              r_rx_valid,  w_rx_valid;
   logic              r_frame_err, w_frame_err;

   logic [FW-1:0]     w_frame;
   logic [1:0]        w_cmd;

   assign w_frame = {r_rx_sh[FW-2:0], MOSI};
   assign w_cmd   = w_frame[FW-1:FW-2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rx_sh     <= '0;
         r_tx_sh     <= '0;
         r_mode      <= 1'b0;
         r_addr_done <= 1'b0;
         r_miso      <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_rx_sh     <= w_rx_sh;
         r_tx_sh     <= w_tx_sh;
         r_mode      <= w_mode;
         r_addr_done <= w_addr_done;
         r_miso      <= w_miso;
         r_rx_data   <= w_rx_data;
         r_rx_valid  <= w_rx_valid;
         r_frame_err <= w_frame_err;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_rx_sh     = r_rx_sh;
      w_tx_sh     = r_tx_sh;
      w_mode      = r_mode;
      w_addr_done = r_addr_done;
      w_miso      = 1'b0;
      w_rx_data   = r_rx_data;
      w_rx_valid  = 1'b0;
      w_frame_err = 1'b0;

      // SS_n release beats everything; only a frame caught mid-transfer is an error
      if (r_state != IDLE && SS_n) begin
         w_state     = IDLE;
         w_cnt       = '0;
         w_rx_sh     = '0;
         w_tx_sh     = '0;
         w_frame_err = (r_state == RECV) || (r_state == WAIT_TX) || (r_state == SEND);
      end else begin
         case (r_state)
            IDLE: begin
               w_cnt   = '0;
               w_rx_sh = '0;
               w_tx_sh = '0;
               if (!SS_n) w_state = CHK_CMD;
            end
            CHK_CMD: begin
               w_mode  = MOSI;
               w_state = RECV;
            end
            RECV: begin
               w_rx_sh = w_frame;
               if (r_cnt == CW'(FW - 1)) begin
                  w_cnt = '0;
                  if (r_mode != w_cmd[1]) begin
                     w_frame_err = 1'b1;
                     w_state     = DONE;
                  end else if (w_cmd == 2'b11 && !r_addr_done) begin
                     w_frame_err = 1'b1;
                     w_state     = DONE;
                  end else begin
                     w_rx_data  = w_frame;
                     w_rx_valid = 1'b1;
                     if (w_cmd == 2'b10) w_addr_done = 1'b1;
                     if (w_cmd == 2'b11) begin
                        w_addr_done = 1'b0;
                        w_state     = WAIT_TX;
                     end else begin
                        w_state = DONE;
                     end
                  end
               end else begin
                  w_cnt = r_cnt + CW'(1);
               end
            end
            WAIT_TX: begin
               if (tx_valid) begin
                  w_miso  = tx_data[DATA_W-1];
                  w_tx_sh = tx_data << 1;
                  w_cnt   = '0;
                  w_state = SEND;
               end
            end
            SEND: begin
               // MSB already left in WAIT_TX; DATA_W-1 more bits, then one idle edge
               if (r_cnt == CW'(DATA_W - 1)) begin
                  w_cnt   = '0;
                  w_state = DONE;
               end else begin
                  w_miso  = r_tx_sh[DATA_W-1];
                  w_tx_sh = r_tx_sh << 1;
                  w_cnt   = r_cnt + CW'(1);
               end
            end
            DONE:    w_state = DONE;
            default: w_state = IDLE;
         endcase
      end
   end

   assign MISO      = r_miso;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: directed and random frames on DATA_W=8 and 16
// instances, checked cycle by cycle against a frame-level reference model.
module tb_spi_slave_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        ss8 = 1'b1, mosi8 = 1'b0, txv8 = 1'b0, miso8, rxv8, fe8;
   logic [7:0]  txd8 = '0;
   logic [9:0]  rxd8;
   logic        ss16 = 1'b1, mosi16 = 1'b0, txv16 = 1'b0, miso16, rxv16, fe16;
   logic [15:0] txd16 = '0;
   logic [17:0] rxd16;

   spi_slave_ctrl #(.DATA_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss8), .MOSI(mosi8), .MISO(miso8),
      .rx_data(rxd8), .rx_valid(rxv8), .tx_data(txd8), .tx_valid(txv8),
      .frame_err(fe8));

   spi_slave_ctrl #(.DATA_W(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
      .rx_data(rxd16), .rx_valid(rxv16), .tx_data(txd16), .tx_valid(txv16),
      .frame_err(fe16));

   int checks = 0;
   int errors = 0;

   // reference model: last accepted frame and read-address ordering flag
   logic [17:0] m_rx [2];
   bit          m_ad [2];

   function automatic int fw(bit sel); return sel ? 18 : 10; endfunction
   function automatic int dw(bit sel); return sel ? 16 : 8;  endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(bit sel, logic ss, logic mosi, logic txv, logic [15:0] txd);
      if (sel) begin
         ss16 = ss; mosi16 = mosi; txv16 = txv; txd16 = txd;
      end else begin
         ss8 = ss; mosi8 = mosi; txv8 = txv; txd8 = txd[7:0];
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(bit sel, string tag, logic miso_e, logic rxv_e, logic fe_e);
      chk({tag, ".miso"}, 32'(sel ? miso16 : miso8), 32'(miso_e));
      chk({tag, ".rx_valid"}, 32'(sel ? rxv16 : rxv8), 32'(rxv_e));
      chk({tag, ".frame_err"}, 32'(sel ? fe16 : fe8), 32'(fe_e));
      chk({tag, ".rx_data"}, sel ? 32'(rxd16) : 32'(rxd8), 32'(m_rx[sel]));
   endtask

   task automatic model_reset;
      m_rx[0] = '0; m_rx[1] = '0;
      m_ad[0] = 1'b0; m_ad[1] = 1'b0;
   endtask

   // abort_at: -1 full frame, -2 drop SS in CHK_CMD, 0..F-1 drop SS after that many
   // frame bits, F+1 drop in WAIT_TX, F+2 drop mid-SEND, F+3 reset mid-SEND
   task automatic run_frame(bit sel, bit m, logic [1:0] cmd, logic [15:0] pay,
                            int abort_at, int tx_delay, logic [15:0] txd, bit hold_txv);
      int          F = fw(sel);
      int          W = dw(sel);
      logic [17:0] frame;
      bit          acc;
      frame = sel ? {cmd, pay} : {8'b0, cmd, pay[7:0]};
      drv(sel, 1'b0, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "e0", 0, 0, 0);
      if (abort_at == -2) begin
         drv(sel, 1'b1, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "ab_chk", 0, 0, 0);
         return;
      end
      drv(sel, 1'b0, m, 1'b0, 16'h0); tick; chk_out(sel, "e1", 0, 0, 0);
      for (int i = F - 1; i >= 0; i--) begin
         if (abort_at == F - 1 - i) begin
            drv(sel, 1'b1, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "ab_rx", 0, 0, 1);
            return;
         end
         drv(sel, 1'b0, frame[i], 1'b0, 16'h0); tick;
         if (i > 0) chk_out(sel, "rx", 0, 0, 0);
      end
      acc = (m == cmd[1]) && !(cmd == 2'b11 && !m_ad[sel]);
      if (acc) begin
         m_rx[sel] = frame;
         if (cmd == 2'b10) m_ad[sel] = 1'b1;
         if (cmd == 2'b11) m_ad[sel] = 1'b0;
      end
      chk_out(sel, "end", 0, acc, !acc);
      if (acc && cmd == 2'b11) begin
         for (int d = 0; d < tx_delay; d++) begin
            drv(sel, 1'b0, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "wait", 0, 0, 0);
         end
         if (abort_at == F + 1) begin
            drv(sel, 1'b1, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "ab_wait", 0, 0, 1);
            return;
         end
         drv(sel, 1'b0, 1'b0, 1'b1, txd); tick; chk_out(sel, "tx_msb", txd[W-1], 0, 0);
         for (int j = W - 2; j >= 0; j--) begin
            if (abort_at == F + 3 && j == W - 4) begin
               rst_n = 1'b0;
               model_reset();
               #1;
               chk_out(sel, "rst_send", 0, 0, 0);
               drv(sel, 1'b1, 1'b0, 1'b0, 16'h0);
               #3;
               rst_n = 1'b1;
               tick;
               return;
            end
            if (abort_at == F + 2 && j == W - 4) begin
               drv(sel, 1'b1, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "ab_send", 0, 0, 1);
               return;
            end
            drv(sel, 1'b0, 1'b0, hold_txv, hold_txv ? ~txd : 16'h0); tick;
            chk_out(sel, "tx", txd[j], 0, 0);
         end
         drv(sel, 1'b0, 1'b0, hold_txv, ~txd); tick; chk_out(sel, "tx_end", 0, 0, 0);
      end
      drv(sel, 1'b0, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "done", 0, 0, 0);
      drv(sel, 1'b1, 1'b0, 1'b0, 16'h0); tick; chk_out(sel, "release", 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      tick; tick;
      chk_out(0, "reset8", 0, 0, 0);
      chk_out(1, "reset16", 0, 0, 0);
      rst_n = 1'b1;
      tick;

      // writes, then a read address/data pair with a 0xC3 response
      run_frame(0, 1'b0, 2'b00, 16'h00A5, -1, 0, 16'h0, 1'b0);
      run_frame(0, 1'b0, 2'b01, 16'h003C, -1, 0, 16'h0, 1'b0);
      run_frame(0, 1'b1, 2'b10, 16'h0012, -1, 0, 16'h0, 1'b0);
      run_frame(0, 1'b1, 2'b11, 16'h0000, -1, 1, 16'h00C3, 1'b0);
      // ordering error (address consumed) and mode mismatch
      run_frame(0, 1'b1, 2'b11, 16'h0000, -1, 0, 16'h0, 1'b0);
      run_frame(0, 1'b0, 2'b10, 16'h0055, -1, 0, 16'h0, 1'b0);
      // truncation after 5 payload bits, then an immediate full frame
      run_frame(0, 1'b0, 2'b01, 16'h00AA, 7, 0, 16'h0, 1'b0);
      run_frame(0, 1'b0, 2'b01, 16'h00FF, -1, 0, 16'h0, 1'b0);
      // reset mid-SEND, then a read-data frame must be rejected
      run_frame(0, 1'b1, 2'b10, 16'h0077, -1, 0, 16'h0, 1'b0);
      run_frame(0, 1'b1, 2'b11, 16'h0000, 13, 0, 16'h00FF, 1'b0);
      run_frame(0, 1'b1, 2'b11, 16'h0000, -1, 0, 16'h0, 1'b0);
      // early SS_n release in CHK_CMD, WAIT_TX and SEND
      run_frame(0, 1'b0, 2'b00, 16'h0011, -2, 0, 16'h0, 1'b0);
      run_frame(0, 1'b1, 2'b10, 16'h0021, -1, 0, 16'h0, 1'b0);
      run_frame(0, 1'b1, 2'b11, 16'h0000, 11, 2, 16'h00F0, 1'b0);
      run_frame(0, 1'b1, 2'b10, 16'h0022, -1, 0, 16'h0, 1'b0);
      run_frame(0, 1'b1, 2'b11, 16'h0000, 12, 0, 16'h00FF, 1'b0);
      // wide instance
      run_frame(1, 1'b0, 2'b01, 16'hBEEF, -1, 0, 16'h0, 1'b0);
      run_frame(1, 1'b1, 2'b10, 16'h1234, -1, 0, 16'h0, 1'b0);
      run_frame(1, 1'b1, 2'b11, 16'h0000, -1, 2, 16'h8001, 1'b1);

      for (int n = 0; n < 60; n++) begin
         bit          sel, m, hold;
         logic [1:0]  cmd;
         logic [15:0] pay, txd;
         int          ab, r, gap;
         sel  = 1'($urandom);
         m    = 1'($urandom);
         cmd  = 2'($urandom);
         if ($urandom_range(0, 2) == 0) cmd = {m, 1'b1};
         pay  = 16'($urandom);
         txd  = 16'($urandom);
         hold = 1'($urandom);
         r    = int'($urandom_range(0, 9));
         case (r)
            0:       ab = int'($urandom_range(0, fw(sel) - 1));
            1:       ab = fw(sel) + 1;
            2:       ab = fw(sel) + 2;
            3:       ab = -2;
            default: ab = -1;
         endcase
         run_frame(sel, m, cmd, pay, ab, int'($urandom_range(0, 3)), txd, hold);
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            tick;
            chk_out(sel, "gap", 0, 0, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Parametrised SPI slave front-end that sits between an external SPI master and the on-chip RAM/register wrapper. It deserialises framed commands of DATA_W+2 bits into a parallel word with a one-cycle valid strobe. For read-data commands it serialises a DATA_W-bit response word back onto MISO under a tx_valid handshake. It also enforces read-address/read-data ordering and flags malformed or truncated frames.

## Interface
- DATA_W, default 8: payload width; received frame is DATA_W+2 bits (2-bit command + payload), response word is DATA_W bits.
- clk  in  1  system clock; SPI bit clock is clk, and SS_n and MOSI are synchronous to it.
- rst_n  in  1  reset, asynchronous, active-low.
- SS_n  in  1  slave select, active-low; frame boundary.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first; 0 when not sending.
- rx_data  out  DATA_W+2  last accepted frame: [DATA_W+1:DATA_W] = command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [DATA_W-1:0] = payload.
- rx_valid  out  1  one-cycle strobe: rx_data updated.
- tx_data  in  DATA_W  response word for a rd-data frame.
- tx_valid  in  1  tx_data valid; sampled only in WAIT_TX.
- frame_err  out  1  one-cycle strobe: frame rejected or truncated.

## Operation
- States:
  - IDLE
  - CHK_CMD
  - RECV
  - WAIT_TX
  - SEND
  - DONE
- Reset (async) and IDLE:
  - State IDLE; MISO=0, rx_valid=0, frame_err=0, rx_data=0.
  - Bit counter, shift registers and addr_done flag cleared.
- IDLE: SS_n=0 sampled -> CHK_CMD.
- CHK_CMD: sample MOSI as mode bit M (0 write, 1 read) -> RECV.
- RECV:
  - Shift in DATA_W+2 bits MSB first, one per edge.
  - On the last bit, the frame is checked, in this order:
    - If M != cmd[1]: frame_err, no rx_valid -> DONE.
    - If cmd=11 and addr_done=0: frame_err, no rx_valid -> DONE.
    - Otherwise: rx_data <= frame, rx_valid pulse.
      - cmd 10 sets addr_done; cmd 11 clears it.
      - Next state: cmd 11 -> WAIT_TX; else DONE.
- WAIT_TX:
  - MISO=0.
  - On an edge with tx_valid=1: capture tx_data, MISO <= tx_data[DATA_W-1], go to SEND.
- SEND:
  - Drive the remaining DATA_W-1 bits on successive edges.
  - After bit 0 has been driven for one cycle -> DONE with MISO=0.
- DONE: MISO=0; wait for SS_n=1.
- Early SS_n deassertion:
  - SS_n=1 sampled in any non-IDLE state -> IDLE next cycle; counters cleared, MISO=0.
  - frame_err pulses if the state was RECV, WAIT_TX or SEND; no pulse from CHK_CMD or DONE.
  - rx_data keeps its last accepted value; addr_done is unchanged.
- Reset mid-frame: immediate IDLE, all outputs 0, addr_done cleared.

## Timing
- Edge E0 samples SS_n=0 in IDLE. E1 samples M. E2..E(DATA_W+3) sample payload bits cmd[1] .. payload[0].
- rx_valid/frame_err is high in the cycle after E(DATA_W+3), for exactly one cycle; rx_data is stable from that cycle until the next accepted frame.
- WAIT_TX entered after E(DATA_W+3). If tx_valid is sampled at edge T, the MSB appears on MISO after T and one bit is shifted per cycle. The LSB is valid in the cycle after T+DATA_W-1; MISO=0 from T+DATA_W.
- tx_valid outside WAIT_TX is ignored; tx_valid held high in WAIT_TX is consumed once.
- SS_n rising is seen with one edge of latency; the frame_err pulse is in the cycle after that edge.
- Back-to-back frames: SS_n may go low in the cycle right after returning to IDLE.
- WAIT_TX has no timeout.

## Test plan
- Write frames: M=0, frame 00_0xA5 then 01_0x3C (DATA_W=8) -> rx_valid once per frame, rx_data=0x0A5 then 0x13C, MISO stays 0, frame_err=0.
- Read sequence:
  - Stimulus: M=1, frame 10_0x12; then M=1, frame 11_0x00; tx_valid with tx_data=0xC3 two cycles after the frame ends.
  - Response: two rx_valid pulses, MISO = 1,1,0,0,0,0,1,1 starting the cycle after tx_valid, then 0.
- Ordering error: frame 11_0x00 with no prior 10 frame, and after reset -> frame_err pulse, no rx_valid, MISO 0.
- Mode mismatch: M=0 with frame 10_0x55 -> frame_err, rx_data unchanged.
- Truncation and reset:
  - SS_n high after 5 payload bits -> frame_err one cycle, state IDLE, then an immediate full write frame 01_0xFF accepted.
  - rst_n low mid-SEND -> MISO=0 at once; a subsequent 11 frame errors (addr_done cleared).
- DATA_W=16 instance: write 01_0xBEEF -> rx_data=0x1BEEF. Read with tx_data=0x8001 -> 16-bit MISO stream 1,0,...,0,1.
